// File: rtl/dmux_stream_pkg.sv
// Shared types and defaults for the dmux_stream demultiplexer and its slots.
// Optional per-channel transfer counters are enabled by DMUX_STREAM_CNT_EN.
package dmux_pkg;

    localparam int DMUX_WIDTH = 16;
    localparam int DMUX_N_OUT = 2;
    localparam int CNT_W      = 16;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_t;

    // Smallest number of bits able to index 'value' distinct items.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/dmux_stream_slot.sv
// One-deep holding register for a single dmux_stream output channel.
// With DMUX_STREAM_CNT_EN defined it also counts drain handshakes.
module dmux_slot
    import dmux_pkg::*;
#(
    parameter int WIDTH = DMUX_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic             o_can_accept
`ifdef DMUX_STREAM_CNT_EN
    ,
    output logic [CNT_W-1:0] o_xfer_cnt
`endif
);

    slot_state_t      r_state;
    slot_state_t      w_next_state;
    logic [WIDTH-1:0] r_data;
    logic             w_drain;

    assign w_drain      = (r_state == FULL) & i_ready;
    assign o_valid      = (r_state == FULL);
    assign o_data       = r_data;
    assign o_can_accept = (r_state == EMPTY) | i_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    // A refill in the same cycle as a drain keeps the slot FULL with no bubble.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            EMPTY:   if (i_load) w_next_state = FULL;
            FULL:    if (w_drain && !i_load) w_next_state = EMPTY;
            default: w_next_state = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_data <= '0;
        end else if (i_load) begin
            r_data <= i_data;
        end
    end

`ifdef DMUX_STREAM_CNT_EN
    logic [CNT_W-1:0] r_xfer_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_xfer_cnt <= '0;
        end else if (w_drain) begin
            r_xfer_cnt <= r_xfer_cnt + 1'b1;
        end
    end

    assign o_xfer_cnt = r_xfer_cnt;
`endif

endmodule

// File: rtl/dmux_stream.sv
// Registered valid/ready demultiplexer steering each word to channel in_sel.
// Defining DMUX_STREAM_CNT_EN adds per-channel drain counters on xfer_cnt.
module dmux_stream
    import dmux_pkg::*;
#(
    parameter int WIDTH = DMUX_WIDTH,
    parameter int N_OUT = DMUX_N_OUT,
    parameter int SEL_W = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    input  logic [SEL_W-1:0]       in_sel,
    output logic [N_OUT-1:0]       out_valid,
    input  logic [N_OUT-1:0]       out_ready,
    output logic [N_OUT*WIDTH-1:0] out_data,
    output logic                   sel_err
`ifdef DMUX_STREAM_CNT_EN
    ,
    output logic [N_OUT*CNT_W-1:0] xfer_cnt
`endif
);

    if (SEL_W < clog2(N_OUT)) begin : g_sel_w_check
        $error("dmux_stream: SEL_W too narrow to address N_OUT channels");
    end

    logic [N_OUT-1:0] w_hit;
    logic [N_OUT-1:0] w_slot_ready;
    logic [N_OUT-1:0] w_load;
    logic             w_in_range;
    logic             w_accept;
    logic             r_sel_err;

    // Out-of-range selects are always accepted so a bad index cannot wedge the input.
    assign w_in_range = |w_hit;
    assign in_ready   = !w_in_range | (|(w_hit & w_slot_ready));
    assign w_accept   = in_valid & in_ready;

    for (genvar k = 0; k < N_OUT; k++) begin : g_slot
        assign w_hit[k]  = (in_sel == SEL_W'(k));
        assign w_load[k] = w_accept & w_hit[k];

        dmux_slot #(
            .WIDTH(WIDTH)
        ) u_slot (
            .clk         (clk),
            .rst_n       (rst_n),
            .i_load      (w_load[k]),
            .i_data      (in_data),
            .i_ready     (out_ready[k]),
            .o_valid     (out_valid[k]),
            .o_data      (out_data[k*WIDTH +: WIDTH]),
            .o_can_accept(w_slot_ready[k])
`ifdef DMUX_STREAM_CNT_EN
            ,
            .o_xfer_cnt  (xfer_cnt[k*CNT_W +: CNT_W])
`endif
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sel_err <= 1'b0;
        end else begin
            r_sel_err <= w_accept & !w_in_range;
        end
    end

    assign sel_err = r_sel_err;

endmodule

// File: tb/tb_dmux_stream.sv
// Self-checking bench for dmux_stream: directed vectors with literal expectations
// plus a per-cycle occupancy model of each channel.
module tb_dmux_stream;

    localparam int WIDTH = 16;
    localparam int N_OUT = 2;
    localparam int SEL_W = 4;

    logic                   clk;
    logic                   rst_n;
    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       in_data;
    logic [SEL_W-1:0]       in_sel;
    logic [N_OUT-1:0]       out_valid;
    logic [N_OUT-1:0]       out_ready;
    logic [N_OUT*WIDTH-1:0] out_data;
    logic                   sel_err;
`ifdef DMUX_STREAM_CNT_EN
    logic [N_OUT*16-1:0]    xfer_cnt;
`endif

    int nChecks = 0;
    int nErrors = 0;

    dmux_stream #(
        .WIDTH(WIDTH),
        .N_OUT(N_OUT),
        .SEL_W(SEL_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .sel_err  (sel_err)
`ifdef DMUX_STREAM_CNT_EN
        ,
        .xfer_cnt (xfer_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nErrors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Channel model: each channel holds 0 or 1 words, shows the last word loaded,
    // and a word may enter when the channel is empty or being drained this cycle.
    int          mCount [N_OUT];
    logic [15:0] mLast  [N_OUT];
    int          mXfer  [N_OUT];
    bit          mSelErr;
    bit          modelLive = 0;

    always @(negedge clk) begin
        int  s;
        bit  expRdy;
        bit  acc;
        s = int'(in_sel);
        expRdy = (s >= N_OUT) ? 1'b1 : ((mCount[s] == 0) || (out_ready[s] == 1'b1));
        if (modelLive) begin
            checkOutput("model_in_ready", 64'(in_ready), 64'(expRdy));
            checkOutput("model_sel_err", 64'(sel_err), 64'(mSelErr));
            for (int k = 0; k < N_OUT; k++) begin
                checkOutput($sformatf("model_out_valid%0d", k), 64'(out_valid[k]), 64'(mCount[k] > 0));
                checkOutput($sformatf("model_out_data%0d", k), 64'(out_data[k*WIDTH +: WIDTH]), 64'(mLast[k]));
`ifdef DMUX_STREAM_CNT_EN
                checkOutput($sformatf("model_xfer_cnt%0d", k), 64'(xfer_cnt[k*16 +: 16]), 64'(mXfer[k] % 65536));
`endif
            end
        end
        if (!rst_n) begin
            for (int k = 0; k < N_OUT; k++) begin
                mCount[k] = 0;
                mLast[k]  = '0;
                mXfer[k]  = 0;
            end
            mSelErr   = 1'b0;
            modelLive = 1'b1;
        end else if (modelLive) begin
            for (int k = 0; k < N_OUT; k++) begin
                if (mCount[k] > 0 && out_ready[k]) begin
                    mCount[k]--;
                    mXfer[k]++;
                end
            end
            acc     = in_valid && expRdy;
            mSelErr = acc && (s >= N_OUT);
            if (acc && s < N_OUT) begin
                mCount[s]++;
                mLast[s] = in_data;
            end
        end
    end

    typedef struct {
        bit          v;
        logic [3:0]  sel;
        logic [15:0] data;
        logic [1:0]  ordy;
        bit          expRdy;
        logic [1:0]  expOv;
        logic [15:0] expD0;
        logic [15:0] expD1;
        bit          expErr;
    } vec_t;

    vec_t vecs [17];

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input bit v, input logic [3:0] sel, input logic [15:0] data, input logic [1:0] ordy);
        in_valid  = v;
        in_sel    = sel;
        in_data   = data;
        out_ready = ordy;
    endtask

    initial begin
        vecs = '{
            '{1'b1, 4'd0, 16'h1234, 2'b11, 1'b1, 2'b01, 16'h1234, 16'h0000, 1'b0},
            '{1'b1, 4'd1, 16'hBEEF, 2'b11, 1'b1, 2'b10, 16'h1234, 16'hBEEF, 1'b0},
            '{1'b0, 4'd0, 16'h0000, 2'b11, 1'b1, 2'b00, 16'h1234, 16'hBEEF, 1'b0},
            '{1'b1, 4'd0, 16'hA001, 2'b10, 1'b1, 2'b01, 16'hA001, 16'hBEEF, 1'b0},
            '{1'b1, 4'd0, 16'hA002, 2'b10, 1'b0, 2'b01, 16'hA001, 16'hBEEF, 1'b0},
            '{1'b1, 4'd1, 16'hB001, 2'b10, 1'b1, 2'b11, 16'hA001, 16'hB001, 1'b0},
            '{1'b1, 4'd0, 16'hA002, 2'b10, 1'b0, 2'b01, 16'hA001, 16'hB001, 1'b0},
            '{1'b1, 4'd1, 16'hB002, 2'b10, 1'b1, 2'b11, 16'hA001, 16'hB002, 1'b0},
            '{1'b1, 4'd1, 16'hB003, 2'b10, 1'b1, 2'b11, 16'hA001, 16'hB003, 1'b0},
            '{1'b1, 4'd0, 16'hA002, 2'b11, 1'b1, 2'b01, 16'hA002, 16'hB003, 1'b0},
            '{1'b1, 4'd0, 16'hA003, 2'b11, 1'b1, 2'b01, 16'hA003, 16'hB003, 1'b0},
            '{1'b0, 4'd0, 16'h0000, 2'b11, 1'b1, 2'b00, 16'hA003, 16'hB003, 1'b0},
            '{1'b1, 4'd3, 16'hAAAA, 2'b11, 1'b1, 2'b00, 16'hA003, 16'hB003, 1'b1},
            '{1'b0, 4'd0, 16'h0000, 2'b11, 1'b1, 2'b00, 16'hA003, 16'hB003, 1'b0},
            '{1'b1, 4'd0, 16'hC000, 2'b00, 1'b1, 2'b01, 16'hC000, 16'hB003, 1'b0},
            '{1'b1, 4'd3, 16'hAAAA, 2'b00, 1'b1, 2'b01, 16'hC000, 16'hB003, 1'b1},
            '{1'b0, 4'd0, 16'h0000, 2'b11, 1'b1, 2'b00, 16'hC000, 16'hB003, 1'b0}
        };

        // Reset held two cycles while a word is offered: nothing may be captured.
        rst_n = 1'b0;
        applyStimulus(1'b1, 4'd0, 16'h5555, 2'b00);
        tick();
        tick();
        checkOutput("reset_out_valid", 64'(out_valid), 64'(2'b00));
        checkOutput("reset_sel_err", 64'(sel_err), 64'(1'b0));
        checkOutput("reset_out_data", 64'(out_data), 64'(32'h0));

        // First accept lands at the first edge after release.
        rst_n = 1'b1;
        tick();
        checkOutput("release_out_valid", 64'(out_valid), 64'(2'b01));
        checkOutput("release_out_data0", 64'(out_data[15:0]), 64'(16'h5555));
        applyStimulus(1'b0, 4'd0, 16'h0000, 2'b11);
        tick();
        checkOutput("release_drained", 64'(out_valid), 64'(2'b00));

        // Routing, backpressure isolation and bad-select vectors.
        for (int i = 0; i < 17; i++) begin
            applyStimulus(vecs[i].v, vecs[i].sel, vecs[i].data, vecs[i].ordy);
            #1;
            checkOutput($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'(vecs[i].expRdy));
            tick();
            checkOutput($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].expOv));
            checkOutput($sformatf("vec%0d_data0", i), 64'(out_data[15:0]), 64'(vecs[i].expD0));
            checkOutput($sformatf("vec%0d_data1", i), 64'(out_data[31:16]), 64'(vecs[i].expD1));
            checkOutput($sformatf("vec%0d_sel_err", i), 64'(sel_err), 64'(vecs[i].expErr));
        end

        // Back-to-back stream on channel 1: one word per cycle, in order.
        for (int i = 0; i < 100; i++) begin
            applyStimulus(1'b1, 4'd1, 16'(i), 2'b11);
            #1;
            checkOutput("stream_in_ready", 64'(in_ready), 64'(1'b1));
            tick();
            checkOutput("stream_out_valid1", 64'(out_valid[1]), 64'(1'b1));
            checkOutput("stream_out_data1", 64'(out_data[31:16]), 64'(i));
        end
        applyStimulus(1'b0, 4'd0, 16'h0000, 2'b11);
        tick();
        checkOutput("stream_done", 64'(out_valid), 64'(2'b00));

        // Reset while a word is held discards it.
        applyStimulus(1'b1, 4'd0, 16'h7777, 2'b00);
        tick();
        checkOutput("midreset_loaded", 64'(out_valid), 64'(2'b01));
        rst_n = 1'b0;
        tick();
        checkOutput("midreset_out_valid", 64'(out_valid), 64'(2'b00));
        checkOutput("midreset_out_data", 64'(out_data), 64'(32'h0));
        rst_n = 1'b1;
        applyStimulus(1'b0, 4'd0, 16'h0000, 2'b00);
        tick();

`ifdef DMUX_STREAM_CNT_EN
        // 65537 drains on channel 0 wrap its counter to 1.
        for (int i = 0; i < 65537; i++) begin
            applyStimulus(1'b1, 4'd0, 16'(i), 2'b11);
            tick();
        end
        applyStimulus(1'b0, 4'd0, 16'h0000, 2'b11);
        tick();
        checkOutput("cnt_wrap0", 64'(xfer_cnt[15:0]), 64'(16'd1));
        checkOutput("cnt_ch1", 64'(xfer_cnt[31:16]), 64'(16'd0));
`endif

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
